// File: rtl/stack_ptr_unit.sv
// rtl/stack_ptr_unit.sv - stack-pointer controller with push/pop over a req/ack data-memory port
//
// Holds the stack pointer (grows downward by 4 bytes per word). A push writes
// push_data to sp-4 and then decrements sp. A pop reads from sp and then
// increments sp. A push at SP_LIMIT is rejected with ovf. A pop at SP_INIT is
// rejected with unf.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, pop         command requests, sampled only in IDLE (push has priority)
//   push_data         word written by a push
//   sp                current stack pointer
//   busy              accepted operation in progress
//   done, ovf, unf    one-cycle completion / rejection pulses
//   pop_data          last successfully popped word
//   mem_req, mem_we   memory request and direction (1 = write)
//   mem_addr          memory address
//   mem_wdata         memory write data
//   mem_ack           memory acknowledge
//   mem_rdata         memory read data, valid with mem_ack on a read
module stack_ptr_unit #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   SP_INIT  = 32'h0000_0100,
  parameter logic [N-1:0]   SP_LIMIT = 32'h0000_00F8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] push_data,
  output logic [N-1:0] sp,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic         unf,
  output logic [N-1:0] pop_data,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2
  } state_t;

  localparam logic [N-1:0] WORD_BYTES = N'(4);

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= SP_INIT;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      pop_data  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Pulses default low; they are raised for exactly one cycle below.
      done <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;

      case (state)
        IDLE: begin
          if (push) begin
            if (sp == SP_LIMIT) begin
              // Stack full: answer immediately, no memory traffic.
              done <= 1'b1;
              ovf  <= 1'b1;
            end else begin
              state     <= PUSH;
              busy      <= 1'b1;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= sp - WORD_BYTES;
              mem_wdata <= push_data;
            end
          end else if (pop) begin
            if (sp == SP_INIT) begin
              // Stack empty: answer immediately, no memory traffic.
              done <= 1'b1;
              unf  <= 1'b1;
            end else begin
              state    <= POP;
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= sp;
            end
          end
        end

        PUSH: begin
          // Request fields stay frozen until the ack is seen.
          if (mem_ack) begin
            sp      <= sp - WORD_BYTES;
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end

        POP: begin
          if (mem_ack) begin
            sp       <= sp + WORD_BYTES;
            pop_data <= mem_rdata;
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_req  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ptr_unit.sv
// tb/tb_stack_ptr_unit.sv - self-checking bench for stack_ptr_unit
module tb_stack_ptr_unit;

  localparam logic [31:0] SP_INIT  = 32'h0000_0100;
  localparam logic [31:0] SP_LIMIT = 32'h0000_00F8;
  localparam int          DEPTH    = int'((SP_INIT - SP_LIMIT) / 4);

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop;
  logic [31:0] push_data;
  logic [31:0] sp;
  logic        busy, done, ovf, unf;
  logic [31:0] pop_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  stack_ptr_unit #(.N(32), .SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .sp(sp), .busy(busy), .done(done), .ovf(ovf), .unf(unf), .pop_data(pop_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the stack as a queue of words.
  logic [31:0] model_q[$];
  logic [31:0] model_pd = '0;

  // Memory responder state.
  logic [31:0] mem_arr [64];
  int          ack_delay = 0;
  int          wcnt      = 0;
  bit          manual    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!manual) begin
        if (mem_req && !mem_ack) begin
          if (wcnt >= ack_delay) begin
            mem_ack = 1'b1;
            if (mem_we) mem_arr[mem_addr[7:2]] = mem_wdata;
            else        mem_rdata = mem_arr[mem_addr[7:2]];
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          mem_ack = 1'b0;
          if (!mem_req) wcnt = 0;
        end
      end
    end
  end

  // Issues one command (inputs held for one sampling edge) and checks the
  // whole transaction against the queue model.
  task automatic run_op(input bit ps, input bit pp, input logic [31:0] d, input int dly,
                        output logic o_ovf, output logic o_unf);
    bit          rej_o, rej_u, acc;
    logic [31:0] ea;
    int          cyc, elat;
    rej_o = ps && (model_q.size() == DEPTH);
    rej_u = !ps && pp && (model_q.size() == 0);
    acc   = (ps || pp) && !rej_o && !rej_u;
    ea    = ps ? SP_INIT - 32'(4 * (model_q.size() + 1)) : SP_INIT - 32'(4 * model_q.size());
    elat  = acc ? dly + 2 : 1;

    ack_delay = dly;
    push = ps; pop = pp; push_data = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      chk("mem_req_active", mem_req, acc);
      chk("busy_active", busy, acc);
      if (acc) begin
        chk("mem_we", mem_we, ps);
        chk("mem_addr", mem_addr, ea);
        if (ps) chk("mem_wdata", mem_wdata, d);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, elat);

    if (acc) begin
      if (ps) model_q.push_back(d);
      else    model_pd = model_q.pop_back();
    end

    o_ovf = ovf;
    o_unf = unf;
    chk("done", done, 1);
    chk("ovf", ovf, rej_o);
    chk("unf", unf, rej_u);
    chk("busy_at_done", busy, 0);
    chk("mem_req_at_done", mem_req, 0);
    chk("sp", sp, SP_INIT - 32'(4 * model_q.size()));
    chk("pop_data", pop_data, model_pd);
    @(posedge clk); #1;
    chk("done_width", done, 0);
    chk("ovf_width", ovf, 0);
    chk("unf_width", unf, 0);
  endtask

  typedef struct {
    bit          ps;
    bit          pp;
    logic [31:0] d;
    int          dly;
    logic [31:0] exp_sp;
    logic        exp_ovf;
    logic        exp_unf;
    logic [31:0] exp_pd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic o_ovf, o_unf;

    vecs[0] = '{1, 0, 32'hDEADBEEF, 0, 32'hFC,  0, 0, 32'h0};
    vecs[1] = '{1, 0, 32'h12345678, 0, 32'hF8,  0, 0, 32'h0};
    vecs[2] = '{1, 0, 32'hAAAA5555, 0, 32'hF8,  1, 0, 32'h0};
    vecs[3] = '{0, 1, 32'h0,        3, 32'hFC,  0, 0, 32'h12345678};
    vecs[4] = '{0, 1, 32'h0,        0, 32'h100, 0, 0, 32'hDEADBEEF};
    vecs[5] = '{0, 1, 32'h0,        0, 32'h100, 0, 1, 32'hDEADBEEF};
    vecs[6] = '{1, 1, 32'h00000055, 0, 32'hFC,  0, 0, 32'hDEADBEEF};
    vecs[7] = '{0, 1, 32'h0,        1, 32'h100, 0, 0, 32'h00000055};

    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp", sp, SP_INIT);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pop_data", pop_data, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].ps, vecs[i].pp, vecs[i].d, vecs[i].dly, o_ovf, o_unf);
      chk($sformatf("tbl%0d_sp", i), sp, vecs[i].exp_sp);
      chk($sformatf("tbl%0d_ovf", i), o_ovf, vecs[i].exp_ovf);
      chk($sformatf("tbl%0d_unf", i), o_unf, vecs[i].exp_unf);
      chk($sformatf("tbl%0d_pop_data", i), pop_data, vecs[i].exp_pd);
    end

    // Reset while a push waits for an ack that never comes.
    manual  = 1'b1;
    mem_ack = 1'b0;
    push = 1'b1; push_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    push = 1'b0;
    chk("rstpush_mem_req", mem_req, 1);
    chk("rstpush_addr", mem_addr, 32'hFC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstpush_req_clr", mem_req, 0);
    chk("rstpush_sp", sp, SP_INIT);
    chk("rstpush_done", done, 0);
    chk("rstpush_busy", busy, 0);
    chk("rstpush_pop_data", pop_data, 0);
    mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("late_ack_done", done, 0);
      chk("late_ack_sp", sp, SP_INIT);
    end
    mem_ack = 1'b0;
    manual  = 1'b0;
    model_q.delete();
    model_pd = '0;

    // Randomized commands against the queue model.
    for (int i = 0; i < 150; i++) begin
      bit ps, pp;
      ps = 1'($urandom % 2);
      pp = 1'($urandom % 2);
      if (!ps && !pp) pp = 1'b1;
      run_op(ps, pp, $urandom, int'($urandom_range(0, 3)), o_ovf, o_unf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
